// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC measurement sequencer.
// Thermometer helpers take the code zero-extended to MAX_TAPS bits plus the
// live tap count; bit taps-1 is the first tap of the line.
package tdc_pkg;

    localparam int unsigned MAX_TAPS = 64;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StArmed,
        StHold
    } tdc_state_e;

    // Fine result width: enough to hold 0..taps ones.
    function automatic int unsigned fine_w(input int unsigned taps);
        return $clog2(taps + 1);
    endfunction

    function automatic int unsigned therm_popcount(input logic [MAX_TAPS-1:0] code,
                                                   input int unsigned       taps);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_TAPS; i++) begin
            if (($unsigned(i) < taps) && code[i]) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

    // Valid when the ones are contiguous from the MSB (no 1 below any 0).
    function automatic logic therm_is_valid(input logic [MAX_TAPS-1:0] code,
                                            input int unsigned       taps);
        logic seen_zero;
        logic ok;
        seen_zero = 1'b0;
        ok        = 1'b1;
        for (int i = MAX_TAPS - 1; i >= 0; i--) begin
            if ($unsigned(i) < taps) begin
                if (code[i]) begin
                    if (seen_zero) begin
                        ok = 1'b0;
                    end
                end else begin
                    seen_zero = 1'b1;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/tdc_controller_if.sv
// Readout and delay-line signals of the TDC sequencer.
// slave: the controller; master: the readout logic / delay line around it.
interface tdc_controller_if #(
    parameter int unsigned TAPS     = 4,
    parameter int unsigned COARSE_W = 16
);
    import tdc_pkg::*;

    localparam int unsigned FINE_W = fine_w(TAPS);

    logic                start;
    logic [COARSE_W-1:0] window_cyc;
    logic                dl_en;
    logic                dl_clr;
    logic [TAPS-1:0]     dl_z;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [COARSE_W-1:0] out_coarse;
    logic [FINE_W-1:0]   out_fine;
    logic                out_timeout;
    logic                out_bubble;

    modport slave (
        input  start, window_cyc, dl_z, out_ready,
        output dl_en, dl_clr, busy, out_valid, out_coarse, out_fine, out_timeout, out_bubble
    );

    modport master (
        output start, window_cyc, dl_z, out_ready,
        input  dl_en, dl_clr, busy, out_valid, out_coarse, out_fine, out_timeout, out_bubble
    );

endinterface

// File: rtl/tdc_therm_decoder.sv
// Combinational thermometer decoder: fine = popcount, bubble = not contiguous
// from the first tap. No bubble correction is applied to the fine value.
module tdc_therm_decoder
    import tdc_pkg::*;
#(
    parameter int unsigned TAPS = 4
) (
    input  logic [TAPS-1:0]           i_dl_z,
    output logic [fine_w(TAPS)-1:0]   o_fine,
    output logic                      o_bubble
);

    localparam int unsigned FINE_W = fine_w(TAPS);

    logic [MAX_TAPS-1:0] w_code;

    // Widen to the helper width, then decode.
    always_comb begin
        w_code   = '0;
        w_code[TAPS-1:0] = i_dl_z;
        o_fine   = FINE_W'(therm_popcount(w_code, TAPS));
        o_bubble = ~therm_is_valid(w_code, TAPS);
    end

endmodule

// File: rtl/tdc_controller.sv
// TDC measurement sequencer: clear, arm, count coarse cycles until a hit or
// window expiry, then hold one {coarse, fine} result on a valid/ready port.
module tdc_controller
    import tdc_pkg::*;
#(
    parameter int unsigned TAPS     = 4,
    parameter int unsigned COARSE_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    tdc_controller_if.slave  bus
);

    localparam int unsigned FINE_W = fine_w(TAPS);

    tdc_state_e          r_state, w_state_nxt;
    logic [COARSE_W-1:0] r_coarse, w_coarse_nxt;
    logic [COARSE_W-1:0] r_window, w_window_nxt;
    logic [COARSE_W-1:0] r_out_coarse, w_out_coarse_nxt;
    logic [FINE_W-1:0]   r_out_fine, w_out_fine_nxt;
    logic                r_out_timeout, w_out_timeout_nxt;
    logic                r_out_bubble, w_out_bubble_nxt;

    logic [FINE_W-1:0]   w_fine;
    logic                w_bubble;
    logic [COARSE_W-1:0] w_last;

    tdc_therm_decoder #(
        .TAPS (TAPS)
    ) u_decoder (
        .i_dl_z   (bus.dl_z),
        .o_fine   (w_fine),
        .o_bubble (w_bubble)
    );

    assign w_last = r_window - COARSE_W'(1);

    // Next-state, counter and result-capture logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_coarse_nxt      = r_coarse;
        w_window_nxt      = r_window;
        w_out_coarse_nxt  = r_out_coarse;
        w_out_fine_nxt    = r_out_fine;
        w_out_timeout_nxt = r_out_timeout;
        w_out_bubble_nxt  = r_out_bubble;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    // A zero window would never time out; run it as one cycle.
                    w_window_nxt = (bus.window_cyc == '0) ? COARSE_W'(1) : bus.window_cyc;
                    w_state_nxt  = StClear;
                end
            end
            StClear: begin
                w_coarse_nxt = '0;
                w_state_nxt  = StArmed;
            end
            StArmed: begin
                // Hit is checked first so a hit in the last cycle beats timeout.
                if (bus.dl_z != '0) begin
                    w_out_coarse_nxt  = r_coarse;
                    w_out_fine_nxt    = w_fine;
                    w_out_bubble_nxt  = w_bubble;
                    w_out_timeout_nxt = 1'b0;
                    w_state_nxt       = StHold;
                end else if (r_coarse == w_last) begin
                    w_out_coarse_nxt  = w_last;
                    w_out_fine_nxt    = '0;
                    w_out_bubble_nxt  = 1'b0;
                    w_out_timeout_nxt = 1'b1;
                    w_state_nxt       = StHold;
                end else begin
                    w_coarse_nxt = r_coarse + COARSE_W'(1);
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State, counter and result registers; reset discards any pending result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_coarse      <= '0;
            r_window      <= COARSE_W'(1);
            r_out_coarse  <= '0;
            r_out_fine    <= '0;
            r_out_timeout <= 1'b0;
            r_out_bubble  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_coarse      <= w_coarse_nxt;
            r_window      <= w_window_nxt;
            r_out_coarse  <= w_out_coarse_nxt;
            r_out_fine    <= w_out_fine_nxt;
            r_out_timeout <= w_out_timeout_nxt;
            r_out_bubble  <= w_out_bubble_nxt;
        end
    end

    // Control outputs decode straight from the state register so reset drops them at once.
    assign bus.dl_en       = (r_state == StArmed);
    assign bus.dl_clr      = (r_state == StClear);
    assign bus.busy        = (r_state != StIdle);
    assign bus.out_valid   = (r_state == StHold);
    assign bus.out_coarse  = r_out_coarse;
    assign bus.out_fine    = r_out_fine;
    assign bus.out_timeout = r_out_timeout;
    assign bus.out_bubble  = r_out_bubble;

endmodule

// File: doc/tdc_controller.md
# tdc_controller

Measurement sequencer for the TDC delay line. It clears and arms the line on a START request and runs a coarse cycle counter while armed. It detects the hit from the sampled thermometer code, decodes the fine value, and presents one {coarse, fine} timestamp per measurement on a valid/ready output port. It sits between the readout logic (START/OUT_*) and the DelayLine instance (DL_EN/DL_CLR/DL_Z).

## Interface
- TAPS, 4: number of delay-line taps (width of DL_Z); ≥2.
- COARSE_W, 16: coarse counter and window width.
- FINE_W (localparam), clog2(TAPS+1): fine output width; 3 for TAPS=4.

- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle measurement request; honoured only in IDLE, ignored otherwise.
- WINDOW_CYC  in  COARSE_W  measurement window in CLK cycles; sampled when START is accepted; 0 treated as 1.
- DL_EN  out  1  arm delay line; high only in ARMED.
- DL_CLR  out  1  clear delay-line taps; high only in CLEAR.
- DL_Z  in  TAPS  thermometer code, already registered on CLK by the delay line. DL_Z[TAPS-1] is the first tap; valid codes are ones contiguous from the MSB.
- BUSY  out  1  high in every state except IDLE.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  consumer accepts result.
- OUT_COARSE  out  COARSE_W  coarse count at hit.
- OUT_FINE  out  FINE_W  number of ones in captured DL_Z.
- OUT_TIMEOUT  out  1  window expired without hit.
- OUT_BUBBLE  out  1  captured code was not a valid thermometer code.

## Operation
- States: IDLE, CLEAR, ARMED, HOLD.
- **IDLE:**
  - START=1: latch window (0→1), go to CLEAR.
- **CLEAR** (exactly 1 cycle):
  - DL_CLR=1, coarse←0.
  - Go to ARMED.
- **ARMED:**
  - DL_EN=1.
  - If DL_Z≠0 (hit): latch OUT_COARSE←coarse, OUT_FINE←popcount(DL_Z), OUT_BUBBLE←(DL_Z not of form 1…10…0), OUT_TIMEOUT←0. Go to HOLD.
  - Else if coarse==window−1: latch OUT_COARSE←window−1, OUT_FINE←0, OUT_BUBBLE←0, OUT_TIMEOUT←1. Go to HOLD.
  - Else coarse←coarse+1.
  - A hit in the last window cycle wins over timeout.
- **HOLD:**
  - OUT_VALID=1. Result fields are stable while OUT_VALID=1 and OUT_READY=0.
  - OUT_VALID&OUT_READY: go to IDLE, OUT_VALID←0.
- START in CLEAR/ARMED/HOLD is dropped; no queueing.
- Coarse counter never wraps: window ≤ 2^COARSE_W−1 guarantees exit before overflow.
- **Bubble codes:** OUT_FINE is still popcount; no correction is applied.

## Timing
- Reset values: state IDLE, coarse 0. DL_EN, DL_CLR, BUSY, OUT_VALID, OUT_TIMEOUT, OUT_BUBBLE all 0. OUT_COARSE and OUT_FINE are 0.
- All outputs are registered. DL_EN and DL_CLR are decoded from the state register.
- START at edge n → DL_CLR high in cycle n+1 → DL_EN high from cycle n+2, with coarse=0 in that first ARMED cycle.
- Hit seen on DL_Z in ARMED cycle with coarse=k → OUT_VALID high the next cycle with OUT_COARSE=k. DL_EN falls in that same cycle.
- Timeout: OUT_VALID high the cycle after the ARMED cycle with coarse=window−1. DL_EN is therefore high for exactly window cycles.
- Minimum START-to-START spacing is 4 cycles with OUT_READY tied high: CLEAR, ARMED, HOLD, IDLE.
- OUT_READY high with OUT_VALID low has no effect.
- RST mid-measurement: DL_EN, DL_CLR and OUT_VALID drop asynchronously. Any pending result is discarded and no partial result is emitted after release.

## Structure
- Package tdc_pkg holds:
  - state enum (IDLE, CLEAR, ARMED, HOLD);
  - function therm_popcount(TAPS);
  - function therm_is_valid(TAPS);
  - FINE_W derivation.
- Sub-module tdc_therm_decoder: combinational. Input DL_Z; outputs fine and bubble. It will be reused by later multi-channel builds.
- Top-level tdc_controller contains the FSM, coarse counter, window register and output registers.

## Test plan
All scenarios use TAPS=4 and COARSE_W=16.
- **Reset defaults:** reset, then START with WINDOW_CYC=8, DL_Z=4'b0000 throughout → DL_EN high 8 cycles, then OUT_VALID=1, OUT_TIMEOUT=1, OUT_COARSE=7, OUT_FINE=0.
- **Normal hit:** WINDOW_CYC=10, DL_Z=4'b1100 in the ARMED cycle with coarse=3 → OUT_COARSE=3, OUT_FINE=2, OUT_BUBBLE=0, OUT_TIMEOUT=0; OUT_VALID the next cycle.
- **Boundary:**
  - WINDOW_CYC=5, DL_Z=4'b1110 at coarse=4 → hit wins: OUT_COARSE=4, OUT_FINE=3, OUT_TIMEOUT=0.
  - WINDOW_CYC=0 → timeout after 1 ARMED cycle, OUT_COARSE=0.
- **Bubble and backpressure:**
  - DL_Z=4'b1010 at coarse=2 → OUT_FINE=2, OUT_BUBBLE=1.
  - Hold OUT_READY=0 for 5 cycles → fields stable.
  - START pulses during HOLD are ignored; BUSY stays 1.
- **Reset mid-measurement:** assert RST in ARMED at coarse=6 → DL_EN low immediately, OUT_VALID never asserts. START after release → clean measurement starting at coarse=0.
